// File: rtl/bcd_accumulate_ctrl.sv
// bcd_accumulate_ctrl: sequenced two-digit BCD accumulator (total 0-99).
// A 4-bit binary operand is accepted over a valid/ready handshake, split
// into BCD ones/tens, then added to the running total one digit per cycle
// (IDLE -> ADD_ONES -> ADD_TENS -> DONE -> IDLE).
// Optional build macro BCD_ACC_SATURATE_EN: when defined, a total above 99
// pins the display at 99 instead of wrapping mod 100.
// PENDING_CLEAR=1 holds a clear seen while busy and applies it on DONE->IDLE.
module bcd_accumulate_ctrl #(
    parameter int PENDING_CLEAR = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ADD_ONES = 2'd1;
    localparam logic [1:0] S_ADD_TENS = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0] r_state;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_overflow;
    logic       r_clear_pend;
    logic [3:0] r_op_ones;
    logic       r_op_tens;
    logic       r_carry;

    logic       w_idle;
    logic       w_accept;
    logic       w_op_gt9;
    logic [3:0] w_op_ones;
    logic [4:0] w_sum_ones;
    logic [4:0] w_sum_tens;
    logic       w_apply_pend;

    // Decimal correction of a digit sum 0-18; 4-bit wraparound makes s-10 exact.
    function automatic logic [3:0] dec_digit(input logic [4:0] s);
        return (s > 5'd9) ? (s[3:0] - 4'd10) : s[3:0];
    endfunction

    assign w_idle       = (r_state == S_IDLE);
    assign op_ready     = w_idle & ~clear;
    assign w_accept     = op_valid & op_ready;
    assign w_op_gt9     = (op > 4'd9);
    assign w_op_ones    = w_op_gt9 ? (op - 4'd10) : op;
    assign w_sum_ones   = {1'b0, r_ones} + {1'b0, r_op_ones};
    assign w_sum_tens   = {1'b0, r_tens} + {4'b0, r_op_tens} + {4'b0, r_carry};
    assign w_apply_pend = (PENDING_CLEAR != 0) && (r_state == S_DONE)
                          && (r_clear_pend || clear);

    assign ones     = r_ones;
    assign tens     = r_tens;
    assign overflow = r_overflow;
    assign busy     = ~w_idle;
    assign done     = (r_state == S_DONE);

    // Sequencer: only IDLE waits on a handshake, the rest advance every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_accept) r_state <= S_ADD_ONES;
                S_ADD_ONES: r_state <= S_ADD_TENS;
                S_ADD_TENS: r_state <= S_DONE;
                S_DONE:     r_state <= S_IDLE;
            endcase
        end
    end

    // Running total and sticky overflow: ones then tens, with clear handling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_ones     <= 4'd0;
                        r_tens     <= 4'd0;
                        r_overflow <= 1'b0;
                    end
                end
                S_ADD_ONES: r_ones <= dec_digit(w_sum_ones);
                S_ADD_TENS: begin
                    if (w_sum_tens > 5'd9) begin
`ifdef BCD_ACC_SATURATE_EN
                        r_tens <= 4'd9;
                        r_ones <= 4'd9;
`else
                        r_tens <= dec_digit(w_sum_tens);
`endif
                        r_overflow <= 1'b1;
                    end else begin
                        r_tens <= w_sum_tens[3:0];
                    end
                end
                S_DONE: begin
                    if (w_apply_pend) begin
                        r_ones     <= 4'd0;
                        r_tens     <= 4'd0;
                        r_overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Deferred clear: remember a clear raised while busy, drop it on return to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clear_pend <= 1'b0;
        end else if (PENDING_CLEAR != 0) begin
            if (r_state == S_DONE) begin
                r_clear_pend <= 1'b0;
            end else if (!w_idle && clear) begin
                r_clear_pend <= 1'b1;
            end
        end
    end

    // Operand digits and ones carry are pure datapath, qualified by state.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_op_ones <= w_op_ones;
            r_op_tens <= w_op_gt9;
        end
        if (r_state == S_ADD_ONES) begin
            r_carry <= (w_sum_ones > 5'd9);
        end
    end

endmodule
